// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: debounced mode/pause buttons, speed-scaled step
// tick, four patterns (rotate left/right, bounce, blink).

module led_seq_debounce #(
  parameter int DB_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= 2'b00;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Level flips on the last mismatch; only a rise is a press.
        stable <= sync[1];
        cnt    <= '0;
        press  <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module led_seq_ctrl #(
  parameter int TICK_DIV  = 5000000,
  parameter int DB_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_pause,
  input  logic [1:0]  sw_speed,
  output logic [15:0] led_out,
  output logic [1:0]  mode_out,
  output logic        paused
);

  localparam int TW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  mode_t         mode;
  mode_t         mode_nxt;
  logic          mode_press;
  logic          pause_press;
  logic          tick;
  logic          dir_left;
  logic [TW-1:0] period;
  logic [TW-1:0] cnt;
  logic [15:0]   seed;

  led_seq_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_mode (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_mode),
    .press(mode_press)
  );

  led_seq_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_pause (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_pause),
    .press(pause_press)
  );

  always_comb begin
    mode_nxt = ROT_L;
    unique case (mode)
      ROT_L:  mode_nxt = ROT_R;
      ROT_R:  mode_nxt = BOUNCE;
      BOUNCE: mode_nxt = BLINK;
      BLINK:  mode_nxt = ROT_L;
      default: mode_nxt = ROT_L;
    endcase
  end

  assign seed = (mode_nxt == BLINK) ? 16'h00FF : 16'h0001;

  // A count already past a shortened period fires on the next edge.
  assign period = TW'(TICK_DIV) >> sw_speed;
  assign tick   = !paused && (cnt >= period - 1'b1);

  assign mode_out = mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= ROT_L;
      led_out  <= 16'h0001;
      paused   <= 1'b0;
      cnt      <= '0;
      dir_left <= 1'b1;
    end else begin
      if (pause_press) begin
        paused <= !paused;
      end
      if (mode_press) begin
        mode     <= mode_nxt;
        led_out  <= seed;
        cnt      <= '0;
        dir_left <= 1'b1;
      end else if (tick) begin
        cnt <= '0;
        unique case (mode)
          ROT_L:  led_out <= {led_out[14:0], led_out[15]};
          ROT_R:  led_out <= {led_out[0], led_out[15:1]};
          BOUNCE: begin
            if (dir_left) begin
              if (led_out[15]) begin
                dir_left <= 1'b0;
                led_out  <= led_out >> 1;
              end else begin
                led_out <= led_out << 1;
              end
            end else begin
              if (led_out[0]) begin
                dir_left <= 1'b1;
                led_out  <= led_out << 1;
              end else begin
                led_out <= led_out >> 1;
              end
            end
          end
          BLINK:  led_out <= ~led_out;
          default: led_out <= led_out;
        endcase
      end else if (!paused) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=8, DB_CYCLES=4:
// table of stimulus rows plus hand sequences for reset corners.

module tb_led_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_mode;
  logic        btn_pause;
  logic [1:0]  sw_speed;
  logic [15:0] led_out;
  logic [1:0]  mode_out;
  logic        paused;

  int n_cmp;
  int n_err;

  typedef struct {
    logic        m;
    logic        p;
    logic [1:0]  s;
    int          n;
    logic [15:0] led;
    logic [1:0]  mode;
    logic        pz;
  } vec_t;

  vec_t tbl[$];

  led_seq_ctrl #(
    .TICK_DIV (8),
    .DB_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_pause(btn_pause),
    .sw_speed (sw_speed),
    .led_out  (led_out),
    .mode_out (mode_out),
    .paused   (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] l,
                         input logic [1:0] m, input logic pz);
    chk({tag, ".led"}, 32'(led_out), 32'(l));
    chk({tag, ".mode"}, 32'(mode_out), 32'(m));
    chk({tag, ".paused"}, 32'(paused), 32'(pz));
  endtask

  task automatic row(input logic m, input logic p, input logic [1:0] s,
                     input int n, input logic [15:0] l,
                     input logic [1:0] md, input logic pz);
    vec_t v;
    v.m = m; v.p = p; v.s = s; v.n = n;
    v.led = l; v.mode = md; v.pz = pz;
    tbl.push_back(v);
  endtask

  task automatic press_mode(input logic [1:0] md, input string tag);
    btn_mode = 1'b1;
    run(7);
    chk({tag, ".mode"}, 32'(mode_out), 32'(md));
    btn_mode = 1'b0;
    run(7);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    btn_mode = 1'b0;
    btn_pause = 1'b0;
    sw_speed = 2'd0;

    // ROT_L from reset
    row(0, 0, 0, 0,   16'h0001, 0, 0);
    row(0, 0, 0, 7,   16'h0001, 0, 0);
    row(0, 0, 0, 1,   16'h0002, 0, 0);
    row(0, 0, 0, 112, 16'h8000, 0, 0);
    row(0, 0, 0, 8,   16'h0001, 0, 0);
    // mode press -> ROT_R on edge 7
    row(1, 0, 0, 6,   16'h0001, 0, 0);
    row(1, 0, 0, 1,   16'h0001, 1, 0);
    row(0, 0, 0, 7,   16'h0001, 1, 0);
    row(0, 0, 0, 1,   16'h8000, 1, 0);
    row(0, 0, 0, 8,   16'h4000, 1, 0);
    // BOUNCE
    row(1, 0, 0, 7,   16'h0001, 2, 0);
    row(0, 0, 0, 8,   16'h0002, 2, 0);
    row(0, 0, 0, 104, 16'h4000, 2, 0);
    row(0, 0, 0, 8,   16'h8000, 2, 0);
    row(0, 0, 0, 8,   16'h4000, 2, 0);
    row(0, 0, 0, 112, 16'h0001, 2, 0);
    row(0, 0, 0, 8,   16'h0002, 2, 0);
    // BLINK, then wrap to ROT_L
    row(1, 0, 0, 7,   16'h00FF, 3, 0);
    row(0, 0, 0, 8,   16'hFF00, 3, 0);
    row(0, 0, 0, 8,   16'h00FF, 3, 0);
    row(1, 0, 0, 7,   16'h0001, 0, 0);
    row(0, 0, 0, 8,   16'h0002, 0, 0);
    // 3-cycle glitch ignored
    row(1, 0, 0, 3,   16'h0002, 0, 0);
    row(0, 0, 0, 5,   16'h0004, 0, 0);
    // pause, hold, resume from held count
    row(0, 1, 0, 7,   16'h0004, 0, 1);
    row(0, 0, 0, 100, 16'h0004, 0, 1);
    row(0, 1, 0, 7,   16'h0004, 0, 0);
    row(0, 0, 0, 1,   16'h0008, 0, 0);
    // speed 2 and shortened period
    row(0, 0, 2, 1,   16'h0008, 0, 0);
    row(0, 0, 2, 1,   16'h0010, 0, 0);
    row(0, 0, 2, 2,   16'h0020, 0, 0);
    row(0, 0, 0, 3,   16'h0020, 0, 0);
    row(0, 0, 2, 1,   16'h0040, 0, 0);
    row(0, 0, 2, 1,   16'h0040, 0, 0);
    row(0, 0, 2, 1,   16'h0080, 0, 0);
    // mode press on the tick edge
    row(0, 0, 0, 1,   16'h0080, 0, 0);
    row(1, 0, 0, 7,   16'h0001, 1, 0);
    row(0, 0, 0, 7,   16'h0001, 1, 0);
    row(0, 0, 0, 1,   16'h8000, 1, 0);
    // mode+pause together, mode while paused
    row(1, 1, 0, 7,   16'h0001, 2, 1);
    row(0, 0, 0, 20,  16'h0001, 2, 1);
    row(1, 0, 0, 7,   16'h00FF, 3, 1);
    row(0, 0, 0, 20,  16'h00FF, 3, 1);
    row(0, 1, 0, 7,   16'h00FF, 3, 0);
    row(0, 0, 0, 7,   16'h00FF, 3, 0);
    row(0, 0, 0, 1,   16'hFF00, 3, 0);

    run(3);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      btn_mode  = tbl[i].m;
      btn_pause = tbl[i].p;
      sw_speed  = tbl[i].s;
      run(tbl[i].n);
      chk_all($sformatf("vec%0d", i), tbl[i].led, tbl[i].mode, tbl[i].pz);
    end
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
    sw_speed  = 2'd0;

    // walk to BOUNCE, reach moving-right, then reset
    press_mode(2'd0, "walk0");
    press_mode(2'd1, "walk1");
    press_mode(2'd2, "walk2");
    chk_all("bnc_seed", 16'h0001, 2'd2, 1'b0);
    run(1);
    chk_all("bnc_s1", 16'h0002, 2'd2, 1'b0);
    run(112);
    chk_all("bnc_s15", 16'h8000, 2'd2, 1'b0);
    run(8);
    chk_all("bnc_s16", 16'h4000, 2'd2, 1'b0);
    btn_pause = 1'b1;
    run(7);
    btn_pause = 1'b0;
    chk_all("bnc_pause", 16'h4000, 2'd2, 1'b1);
    rst = 1'b1;
    run(1);
    chk_all("rst_mid", 16'h0001, 2'd0, 1'b0);
    rst = 1'b0;
    run(7);
    chk_all("rst_hold", 16'h0001, 2'd0, 1'b0);
    run(1);
    chk_all("rst_step", 16'h0002, 2'd0, 1'b0);

    // reset in the middle of a debounce window
    btn_mode = 1'b1;
    run(3);
    rst = 1'b1;
    btn_mode = 1'b0;
    run(1);
    rst = 1'b0;
    run(10);
    chk_all("rst_db", 16'h0002, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5000000, clock cycles per LED step at sw_speed=0 (legal values >= 8).
REQ-002 SHALL have parameter DB_CYCLES, default 200000, debounce stability window in cycles (legal values >= 2).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 btn_mode  in  1  raw asynchronous button; each press advances the pattern mode.
REQ-006 btn_pause  in  1  raw asynchronous button; each press toggles pause.
REQ-007 sw_speed  in  2  speed select; step period = TICK_DIV >> sw_speed cycles.
REQ-008 led_out  out  16  LED pattern, registered.
REQ-009 mode_out  out  2  current mode: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK; registered.
REQ-010 paused  out  1  high while stepping is frozen; registered.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer with a stable level and a mismatch counter.
REQ-012 Debouncer: the counter SHALL increment each cycle the synchronized input differs from the stable level; stable level SHALL take the new value on the DB_CYCLES-th consecutive mismatch; any match SHALL clear the counter.
REQ-013 Press event SHALL be a one-cycle pulse on the stable level's rising edge; releases SHALL generate no event.
REQ-014 Raw high held >= DB_CYCLES+2 cycles SHALL change mode_out on the (DB_CYCLES+3)th rising edge after the raw rise.
REQ-015 Tick counter SHALL count 0..P-1 (P = TICK_DIV >> sw_speed) and assert a step tick on reaching P-1, then wrap to 0.
REQ-016 If sw_speed changes so that count >= new P-1, a tick SHALL fire next cycle and the counter SHALL wrap to 0.
REQ-017 While paused=1, the tick counter SHALL hold its value and no steps SHALL occur.
REQ-018 Mode FSM SHALL advance ROT_L->ROT_R->BOUNCE->BLINK->ROT_L on each mode press.
REQ-019 On a mode change, led_out SHALL load the seed (0x0001 for modes 0-2, 0x00FF for BLINK), the tick counter SHALL clear, and bounce direction SHALL set to left.
REQ-020 ROT_L step SHALL rotate led_out left by 1 (bit15 -> bit0).
REQ-021 ROT_R step SHALL rotate led_out right by 1 (bit0 -> bit15).
REQ-022 BOUNCE step SHALL shift toward the current direction; when the lit bit is bit15 (moving left) or bit0 (moving right), direction SHALL reverse and that same step SHALL shift the opposite way.
REQ-023 BLINK step SHALL invert led_out.
REQ-024 Mode press and step tick in the same cycle: mode reload SHALL win; the step SHALL be discarded.
REQ-025 Mode and pause presses in the same cycle: both SHALL take effect.
REQ-026 Mode press while paused SHALL change mode and reload the seed; paused SHALL stay 1.
REQ-027 Pause press SHALL toggle paused; on resume, counting SHALL continue from the held count.

Reset
REQ-028 On rst: led_out=0x0001, mode_out=0, paused=0, tick counter 0, direction left, synchronizer and stable levels 0, debounce counters 0.
REQ-029 Reset SHALL take priority over all events, including during a debounce window or mid-pattern.

Verification (TICK_DIV=8, DB_CYCLES=4)
REQ-030 Reset, ROT_L, sw_speed=0 -> led_out 0x0001, 0x0002 after 8 cycles; 0x8000 after 15 steps; 0x0001 after step 16.
REQ-031 One mode press -> mode_out=1 on edge 7 after raw rise, led_out=0x0001; next tick -> 0x8000.
REQ-032 BOUNCE -> 0x8000 at step 15, 0x4000 at step 16, 0x0001 at step 30, 0x0002 at step 31.
REQ-033 BLINK -> 0x00FF, 0xFF00, 0x00FF per step; next mode press -> mode_out=0, led_out=0x0001.
REQ-034 3-cycle glitch on btn_mode -> no change; pause press -> led_out frozen 100 cycles; second press resumes; sw_speed=2 -> 2-cycle step period.
REQ-035 rst asserted mid-BOUNCE moving right -> next edge led_out=0x0001, mode_out=0, paused=0; next tick shifts left.
